// File: rtl/sysa_seq.sv
// ---------------------------------------------------------------------------
// sysa_seq -- sequencer for the 3x3 weight-stationary systolic array.
//
// Loads three weight words and three input rows over valid/ready streams,
// clears the array at the start of each job, and steps the array with
// skew-correct flush cycles. The three staggered array output columns are
// captured into a nine-entry result buffer that is read through a
// registered port.
//
// Build option:
//   SYSA_SEQ_RELU_EN  when defined, a captured value with its MSB set
//                     (signed negative) is stored as 0. When undefined,
//                     values are stored unmodified. The read path is the
//                     same in both builds.
//
// Parameters:
//   DW   element width; weight words and rows carry 3 elements
//   OW   array output / result width
//   LAT  enabled steps from row 0 presented to first valid sa_out1 (0..4)
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 job request, honoured only in IDLE
//   w_valid/w_ready/w_data weight word stream, row k in arrival order
//   i_valid/i_ready/i_data input row stream, rows 0..2
//   sa_clr                one-cycle array clear (first LOAD_W cycle)
//   sa_en, sa_in          registered array step enable and input row
//   sa_w                  weights, row k at [k*3*DW +: 3*DW]
//   sa_out1..3            array column outputs
//   res_addr, res_data    result read port, 1-cycle latency, 9..15 -> 0
//   busy                  high whenever the FSM is not in IDLE
//   done                  one-cycle pulse at job end
//   dbg_state             current FSM state (debug visibility)
//
// Handshake semantics (both streams): a word moves at a rising edge where
// valid and ready are both high. ready is decoded from registered state
// only, never from valid, so a producer may hold valid high indefinitely
// and the transfer point is fully determined by ready at that edge.
// ---------------------------------------------------------------------------
module sysa_seq #(
  parameter int DW  = 8,
  parameter int OW  = 16,
  parameter int LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [3*DW-1:0] w_data,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [3*DW-1:0] i_data,
  output logic            sa_clr,
  output logic            sa_en,
  output logic [9*DW-1:0] sa_w,
  output logic [3*DW-1:0] sa_in,
  input  logic [OW-1:0]   sa_out1,
  input  logic [OW-1:0]   sa_out2,
  input  logic [OW-1:0]   sa_out3,
  input  logic [3:0]      res_addr,
  output logic [OW-1:0]   res_data,
  output logic            busy,
  output logic            done,
  output logic [2:0]      dbg_state
);

  // FSM encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_LOAD_I = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Last step index issued before the job ends; rows take steps 0..2 and
  // flush steps fill 3..LAT+4 so the third column drains completely.
  localparam logic [3:0] LAST_STEP = 4'(LAT + 4);

  logic [2:0]    state;
  logic [1:0]    w_cnt;
  logic [1:0]    i_cnt;
  logic [3:0]    step;
  logic [OW-1:0] result [9];

  logic          w_fire;
  logic          i_fire;
  logic          job_go;
  logic [OW-1:0] col [3];
  logic [8:0]    cap_we;
  logic [OW-1:0] cap_val [9];

  // -------------------------------------------------------------------------
  // Output decodes from registered state
  // -------------------------------------------------------------------------
  assign w_ready   = (state == S_LOAD_W);
  assign i_ready   = (state == S_LOAD_I) && (i_cnt != 2'd3);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  assign w_fire = w_valid & w_ready;
  assign i_fire = i_valid & i_ready;
  assign job_go = (state == S_IDLE) && start;

  assign col[0] = sa_out1;
  assign col[1] = sa_out2;
  assign col[2] = sa_out3;

  // Stored form of a captured column value.
  function automatic logic [OW-1:0] store_val(input logic [OW-1:0] v);
`ifdef SYSA_SEQ_RELU_EN
    store_val = v[OW-1] ? '0 : v;
`else
    store_val = v;
`endif
  endfunction

  // -------------------------------------------------------------------------
  // Capture decode. Column j produces its three valid outputs during steps
  // LAT+j .. LAT+j+2 (the array skews each column by one step), so entry
  // 3j+k is written at the edge closing step LAT+j+k. Indexing follows the
  // step counter, so input bubbles never shift results.
  // -------------------------------------------------------------------------
  always_comb begin
    cap_we = '0;
    for (int i = 0; i < 9; i++) begin
      cap_val[i] = '0;
    end
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < 3; k++) begin
        cap_we[3*j+k]  = sa_en && (step == 4'(LAT + j + k));
        cap_val[3*j+k] = store_val(col[j]);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Main FSM, counters and array drive
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      w_cnt  <= '0;
      i_cnt  <= '0;
      step   <= '0;
      sa_clr <= 1'b0;
      sa_en  <= 1'b0;
      sa_w   <= '0;
      sa_in  <= '0;
    end else begin
      sa_clr <= 1'b0;

      // Every cycle with sa_en high is one array step.
      if (sa_en) begin
        step <= step + 4'd1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_LOAD_W;
            sa_clr <= 1'b1;
            w_cnt  <= '0;
            i_cnt  <= '0;
            step   <= '0;
            sa_w   <= '0;
          end
        end

        S_LOAD_W: begin
          if (w_fire) begin
            for (int k = 0; k < 3; k++) begin
              if (w_cnt == 2'(k)) begin
                sa_w[k*3*DW +: 3*DW] <= w_data;
              end
            end
            w_cnt <= w_cnt + 2'd1;
            if (w_cnt == 2'd2) begin
              state <= S_LOAD_I;
            end
          end
        end

        S_LOAD_I: begin
          // An accepted row becomes one step in the next cycle; a missed
          // transfer becomes a bubble with the array held.
          if (i_fire) begin
            sa_en <= 1'b1;
            sa_in <= i_data;
            i_cnt <= i_cnt + 2'd1;
            if (i_cnt == 2'd2) begin
              state <= S_FLUSH;
            end
          end else begin
            sa_en <= 1'b0;
            sa_in <= '0;
          end
        end

        S_FLUSH: begin
          // The first FLUSH cycle still carries the third row; from then on
          // zeros are pushed until the final step has been issued.
          sa_in <= '0;
          if (sa_en && (step == LAST_STEP)) begin
            sa_en <= 1'b0;
            state <= S_DONE;
          end else begin
            sa_en <= 1'b1;
          end
        end

        S_DONE: begin
          // start is deliberately not looked at here.
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          sa_en <= 1'b0;
          sa_in <= '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Result buffer: cleared on job start, written by the capture decode.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        result[i] <= '0;
      end
    end else if (job_go) begin
      for (int i = 0; i < 9; i++) begin
        result[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (cap_we[i]) begin
          result[i] <= cap_val[i];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registered read port. No interlock with an active job: a read while
  // busy returns whatever has been captured so far.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
    end else if (res_addr < 4'd9) begin
      res_data <= result[res_addr];
    end else begin
      res_data <= '0;
    end
  end

endmodule

// File: doc/sysa_seq.md
# sysa_seq

Sequencer for the 3x3 weight-stationary systolic array. It accepts three weight words and three input rows over valid/ready streams, and clears the array before each job. It drives the array's enable and input with skew-correct flush cycles, captures the three staggered output columns into a nine-entry result buffer, and exposes that buffer through a registered read port. It replaces the ad-hoc counters around the array in the Wishbone wrapper, sitting between the input FIFO read side and the array.

## Interface
- DW, 8: element width; rows and weight words carry 3 elements (3*DW bits).
- OW, 16: array output and result width.
- LAT, 1: enabled steps from row 0 presented to first valid sa_out1, range 0..4.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  job request; accepted only in IDLE.
- w_valid / w_ready  in / out  1 / 1  weight word handshake.
- w_data  in  3*DW  weight row k, k=0..2 in arrival order.
- i_valid / i_ready  in / out  1 / 1  input row handshake.
- i_data  in  3*DW  input row r, r=0..2.
- sa_clr  out  1  one-cycle array clear.
- sa_en  out  1  array step enable (registered).
- sa_w  out  9*DW  weights; row k at [k*3*DW +: 3*DW].
- sa_in  out  3*DW  array input row (registered).
- sa_out1, sa_out2, sa_out3  in  OW each  array column outputs.
- res_addr  in  4  result index 0..8.
- res_data  out  OW  result, 1-cycle read latency.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at job end.

## Operation
- States: IDLE, LOAD_W, LOAD_I, FLUSH, DONE.
- IDLE, start=1: go to LOAD_W; zero the result buffer, step and row counters, and sa_w.
  - sa_clr is high for the first LOAD_W cycle.
  - start in any other state is ignored.
- LOAD_W:
  - w_ready=1.
  - Each transfer (w_valid & w_ready at an edge) writes sa_w row w_cnt; w_cnt increments.
  - After the 3rd transfer, go to LOAD_I.
- LOAD_I:
  - i_ready=1 while fewer than 3 rows have been accepted.
  - A row accepted at edge E drives sa_in=i_data and sa_en=1 for the cycle after E; that cycle is one step.
  - If no transfer occurs at E, the next cycle has sa_en=0 and sa_in=0 (bubble; step count frozen).
  - After the 3rd row is accepted, go to FLUSH.
- FLUSH:
  - Each cycle drives sa_en=1 and sa_in=0.
  - Continues until step LAT+4 has been issued, then go to DONE.
- Step counter s:
  - Increments at every edge closing a cycle with sa_en=1.
  - Rows occupy s=0..2; flush occupies s=3..LAT+4.
- Capture, at the edge closing step s, for j=0..2:
  - if LAT+j <= s <= LAT+j+2, then result[3j + s-LAT-j] <= sa_out(j+1).
- DONE: done=1 for one cycle, then IDLE; the result buffer is held.
- Read port:
  - res_data <= result[res_addr] every edge; addr 9..15 returns 0.
  - Reads while busy return partial buffer contents; no protection.
- Reset mid-operation: all state, counters, sa_w, the buffer and all outputs clear immediately; state goes to IDLE.

## Timing
- Reset values: w_ready=0, i_ready=0, sa_clr=0, sa_en=0, sa_w=0, sa_in=0, res_data=0, busy=0, done=0.
- w_ready and i_ready are decoded from registered state only, with no combinational path from w_valid or i_valid.
- Best-case job, start accepted at edge 0 with streams back-to-back:
  - weights accepted at edges 1–3;
  - rows accepted at edges 4–6;
  - steps close at edges 5 to 9+LAT;
  - done is high in the cycle after edge 9+LAT (10 cycles for LAT=1).
- Bubbles during LOAD_I extend the job by one cycle each; capture indexing follows s, not wall-clock time.
- A start asserted in the DONE cycle is ignored; start is accepted from the following IDLE cycle.

## Configuration
- SYSA_SEQ_RELU_EN defined: each captured value whose MSB is set (signed negative) is stored as 0.
- SYSA_SEQ_RELU_EN undefined: values are stored unmodified.
- The read path is identical in both builds.

## Test plan
- Reset and back-to-back job, LAT=1.
  - Stimulus: weights 0x010203, 0x040506, 0x070809; rows 1, 2, 3; bench drives sa_out1=0x1000+s, sa_out2=0x2000+s, sa_out3=0x3000+s.
  - Required: sa_w=0x070809_040506_010203; results 0..8 = 0x1001, 0x1002, 0x1003, 0x2002, 0x2003, 0x2004, 0x3003, 0x3004, 0x3005; done in the cycle after edge 10.
- Bubbles: i_valid low for 2 cycles between rows 1 and 2.
  - Required: sa_en low for exactly 2 cycles; same nine results; done 2 cycles later.
- start pulsed while busy and during DONE.
  - Required: no restart, no sa_clr, results unchanged.
- rst_n asserted in FLUSH.
  - Required: every output is 0 immediately; a new job after release completes correctly.
- SYSA_SEQ_RELU_EN defined, sa_out2 driven to 0xFFF0.
  - Required: results 3..5 = 0.
  - Same stimulus without the macro: results 3..5 = 0xFFF0.
